memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 80 ++++++++
 tb/tb_memory_access.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Pipeline memory stage: execute-to-memory register plus a word-addressed data memory
// with combinational read, range checking and a stall-aware synchronous write port.
module memory_access #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             MA_CLK,
    input  logic             MA_RST,
    input  logic [WIDTH-1:0] MA_AluOutE,
    input  logic [WIDTH-1:0] MA_WriteDataE,
    input  logic [4:0]       MA_WriteRegE,
    input  logic             MA_RegWriteE,
    input  logic             MA_MemToRegE,
    input  logic             MA_MemWriteE,
    input  logic             MA_StallM,
    input  logic             MA_FlushM,
    output logic [WIDTH-1:0] MA_AluOutM,
    output logic [WIDTH-1:0] MA_ReadDataM,
    output logic [4:0]       MA_WriteRegM,
    output logic             MA_RegWriteM,
    output logic             MA_MemToRegM,
    output logic             MA_AddrErrM
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so the byte limit 4*DEPTH is representable even when it overflows WIDTH.
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(4 * DEPTH);

    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_wdata;
    logic [4:0]       r_wreg;
    logic             r_regwrite;
    logic             r_memtoreg;
    logic             r_memwrite;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_inrange;
    logic [AW-1:0]    w_index;
    logic             w_write;

    always_ff @(posedge MA_CLK) begin
        if (MA_RST || MA_FlushM) begin
            r_alu      <= '0;
            r_wdata    <= '0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (!MA_StallM) begin
            r_alu      <= MA_AluOutE;
            r_wdata    <= MA_WriteDataE;
            r_wreg     <= MA_WriteRegE;
            r_regwrite <= MA_RegWriteE;
            r_memtoreg <= MA_MemToRegE;
            r_memwrite <= MA_MemWriteE;
        end
    end

    assign w_inrange = {1'b0, r_alu} < LIMIT;
    assign w_index   = r_alu[AW+1:2];
    assign w_write   = r_memwrite && w_inrange && !MA_StallM;

    // Write uses the pre-edge register contents, so a store commits on the edge that
    // advances the following load into M and that load then sees the new data.
    always_ff @(posedge MA_CLK) begin
        if (MA_RST) begin
            r_mem <= '{default: '0};
        end else if (w_write) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    assign MA_AluOutM   = r_alu;
    assign MA_WriteRegM = r_wreg;
    assign MA_RegWriteM = r_regwrite;
    assign MA_MemToRegM = r_memtoreg;
    assign MA_ReadDataM = w_inrange ? r_mem[w_index] : '0;
    assign MA_AddrErrM  = (r_memwrite || r_memtoreg) && !w_inrange;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vector table for the pipeline corner cases,
// then randomized traffic checked against a behavioural stage/memory model.
module tb_memory_access;

    logic        MA_CLK = 1'b0;
    logic        MA_RST;
    logic [31:0] MA_AluOutE;
    logic [31:0] MA_WriteDataE;
    logic [4:0]  MA_WriteRegE;
    logic        MA_RegWriteE;
    logic        MA_MemToRegE;
    logic        MA_MemWriteE;
    logic        MA_StallM;
    logic        MA_FlushM;
    logic [31:0] MA_AluOutM;
    logic [31:0] MA_ReadDataM;
    logic [4:0]  MA_WriteRegM;
    logic        MA_RegWriteM;
    logic        MA_MemToRegM;
    logic        MA_AddrErrM;

    memory_access #(.WIDTH(32), .DEPTH(64)) dut (
        .MA_CLK        (MA_CLK),
        .MA_RST        (MA_RST),
        .MA_AluOutE    (MA_AluOutE),
        .MA_WriteDataE (MA_WriteDataE),
        .MA_WriteRegE  (MA_WriteRegE),
        .MA_RegWriteE  (MA_RegWriteE),
        .MA_MemToRegE  (MA_MemToRegE),
        .MA_MemWriteE  (MA_MemWriteE),
        .MA_StallM     (MA_StallM),
        .MA_FlushM     (MA_FlushM),
        .MA_AluOutM    (MA_AluOutM),
        .MA_ReadDataM  (MA_ReadDataM),
        .MA_WriteRegM  (MA_WriteRegM),
        .MA_RegWriteM  (MA_RegWriteM),
        .MA_MemToRegM  (MA_MemToRegM),
        .MA_AddrErrM   (MA_AddrErrM)
    );

    always #5 MA_CLK = ~MA_CLK;

    typedef struct {
        logic        rst, stall, flush;
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
        logic        rw, m2r, mw;
        logic [31:0] e_alu, e_rd;
        logic [4:0]  e_wreg;
        logic        e_rw, e_m2r, e_err;
    } vec_t;

    typedef struct {
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
        logic        rw, m2r, mw;
    } stage_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    stage_t      m;
    logic [31:0] mem_m [64];
    vec_t        tbl [$];

    function automatic vec_t v(logic rst, logic stall, logic flush, logic [31:0] alu,
                               logic [31:0] wd, logic [4:0] wreg, logic rw, logic m2r,
                               logic mw, logic [31:0] e_alu, logic [31:0] e_rd,
                               logic [4:0] e_wreg, logic e_rw, logic e_m2r, logic e_err);
        vec_t t;
        t.rst = rst; t.stall = stall; t.flush = flush; t.alu = alu; t.wd = wd;
        t.wreg = wreg; t.rw = rw; t.m2r = m2r; t.mw = mw; t.e_alu = e_alu;
        t.e_rd = e_rd; t.e_wreg = e_wreg; t.e_rw = e_rw; t.e_m2r = e_m2r; t.e_err = e_err;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of execute-side inputs and advances the reference model at the edge.
    task automatic step(logic rst, logic stall, logic flush, logic [31:0] alu, logic [31:0] wd,
                        logic [4:0] wreg, logic rw, logic m2r, logic mw);
        MA_RST = rst; MA_StallM = stall; MA_FlushM = flush;
        MA_AluOutE = alu; MA_WriteDataE = wd; MA_WriteRegE = wreg;
        MA_RegWriteE = rw; MA_MemToRegE = m2r; MA_MemWriteE = mw;
        @(posedge MA_CLK);
        if (rst) begin
            m = '{default: '0};
            for (int i = 0; i < 64; i++) mem_m[i] = '0;
        end else begin
            if (m.mw && m.alu < 32'd256 && !stall) mem_m[m.alu / 4] = m.wd;
            if (flush) m = '{default: '0};
            else if (!stall) begin
                m.alu = alu; m.wd = wd; m.wreg = wreg; m.rw = rw; m.m2r = m2r; m.mw = mw;
            end
        end
        #1;
    endtask

    task automatic check_model();
        logic        inr;
        logic [31:0] rd;
        inr = m.alu < 32'd256;
        rd  = inr ? mem_m[m.alu / 4] : 32'h0;
        check("rnd_alu",   MA_AluOutM, m.alu);
        check("rnd_rdata", MA_ReadDataM, rd);
        check("rnd_wreg",  {27'b0, MA_WriteRegM}, {27'b0, m.wreg});
        check("rnd_rw",    {31'b0, MA_RegWriteM}, {31'b0, m.rw});
        check("rnd_m2r",   {31'b0, MA_MemToRegM}, {31'b0, m.m2r});
        check("rnd_err",   {31'b0, MA_AddrErrM}, {31'b0, (m.mw || m.m2r) && !inr});
    endtask

    initial begin
        m = '{default: '0};
        for (int i = 0; i < 64; i++) mem_m[i] = '0;

        //          rst st fl alu           wd            wr  rw m2r mw | e_alu        e_rd          e_wr rw m2r err
        tbl.push_back(v(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h8,        32'hDEADBEEF, 0, 0, 0, 1,  32'h8,        32'h0,        0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'hB,        32'h0,        5, 1, 1, 0,  32'hB,        32'hDEADBEEF, 5, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h8,        32'h0,        0, 0, 1, 0,  32'h8,        32'hDEADBEEF, 0, 0, 1, 0));
        // store to 0x10 held by a three-cycle stall, committed on release
        tbl.push_back(v(0, 0, 0, 32'h10,       32'h12345678, 3, 0, 0, 1,  32'h10,       32'h0,        3, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'h20,       32'h0000FFFF, 1, 1, 0, 1,  32'h10,       32'h0,        3, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'h20,       32'h0000FFFF, 1, 1, 0, 1,  32'h10,       32'h0,        3, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'h20,       32'h0000FFFF, 1, 1, 0, 1,  32'h10,       32'h0,        3, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h10,       32'h0,        0, 0, 1, 0,  32'h10,       32'h12345678, 0, 0, 1, 0));
        // flush beats stall; flushed store never reaches memory
        tbl.push_back(v(0, 1, 1, 32'h14,       32'hCAFEF00D, 7, 1, 0, 1,  32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h14,       32'h0,        0, 0, 1, 0,  32'h14,       32'h0,        0, 0, 1, 0));
        // range boundary: 0x100 and 0xFFFFFFFC out of range, 0xFC/0xFF last word
        tbl.push_back(v(0, 0, 0, 32'h100,      32'h0,        0, 0, 1, 0,  32'h100,      32'h0,        0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 32'hFFFFFFFC, 32'h11111111, 0, 0, 0, 1,  32'hFFFFFFFC, 32'h0,        0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 32'hFC,       32'h0,        0, 0, 1, 0,  32'hFC,       32'h0,        0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 32'hFF,       32'h0,        0, 0, 1, 0,  32'hFF,       32'h0,        0, 0, 1, 0));
        // reset while a store to 0x4 sits in M; memory is cleared and store is lost
        tbl.push_back(v(0, 0, 0, 32'h4,        32'hA5A5A5A5, 9, 1, 0, 1,  32'h4,        32'h0,        9, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 32'h8,        32'h77777777, 2, 1, 0, 1,  32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h4,        32'h0,        0, 0, 1, 0,  32'h4,        32'h0,        0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 32'h8,        32'h0,        0, 0, 1, 0,  32'h8,        32'h0,        0, 0, 1, 0));

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].stall, tbl[k].flush, tbl[k].alu, tbl[k].wd,
                 tbl[k].wreg, tbl[k].rw, tbl[k].m2r, tbl[k].mw);
            check($sformatf("v%0d_alu", k),   MA_AluOutM, tbl[k].e_alu);
            check($sformatf("v%0d_rdata", k), MA_ReadDataM, tbl[k].e_rd);
            check($sformatf("v%0d_wreg", k),  {27'b0, MA_WriteRegM}, {27'b0, tbl[k].e_wreg});
            check($sformatf("v%0d_rw", k),    {31'b0, MA_RegWriteM}, {31'b0, tbl[k].e_rw});
            check($sformatf("v%0d_m2r", k),   {31'b0, MA_MemToRegM}, {31'b0, tbl[k].e_m2r});
            check($sformatf("v%0d_err", k),   {31'b0, MA_AddrErrM}, {31'b0, tbl[k].e_err});
        end

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'd252 + $urandom_range(0, 8);
                default: a = $urandom_range(0, 255);
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, a, $urandom, 5'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
